// File: rtl/pio_pkg.sv
// Shared constants for the input PIO: register addresses, edge-mode encodings
// and the debounce-length helper used by every debounce lane.
package pio_pkg;

  typedef enum logic [2:0] {
    PIO_ADDR_DATA = 3'd0,
    PIO_ADDR_RAW  = 3'd1,
    PIO_ADDR_MASK = 3'd2,
    PIO_ADDR_EDGE = 3'd3
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Zero and one both collapse to a single-cycle hold, i.e. bypass.
  function automatic int deb_len(input int cycles);
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One debounce lane: the accepted level follows d only after d has differed
// from it for N consecutive clocks; any shorter excursion restarts the count.
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int N  = deb_len(DEBOUNCE_CYCLES);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (d != deb_q) begin
      if (cnt_q == LAST) begin
        deb_d = d;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all lanes update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign q = deb_q;

endmodule

// File: rtl/pio_input_irq_debounced.sv
// Avalon-MM input PIO: synchronise, debounce, edge-detect and capture button
// and switch inputs, with a maskable level interrupt and registered readback.
module pio_input_irq_debounced
  import pio_pkg::*;
#(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 2,
  parameter int W1C_CAPTURE     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d1_q;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_det, clr;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    pio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .reset(reset),
      .d    (sync2_q[i]),
      .q    (deb[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    edge_det = '0;
    if (EDGE_MODE == EDGE_RISE) begin
      edge_det = deb & ~deb_d1_q;
    end else if (EDGE_MODE == EDGE_FALL) begin
      edge_det = ~deb & deb_d1_q;
    end else begin
      edge_det = deb ^ deb_d1_q;
    end
  end

  always_comb begin
    clr        = '0;
    irq_mask_d = irq_mask_q;
    if (wr_en && address == PIO_ADDR_EDGE) begin
      clr = (W1C_CAPTURE != 0) ? writedata[WIDTH-1:0] : '1;
    end
    if (wr_en && address == PIO_ADDR_MASK) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    // A fresh edge is ORed in after the clear so a coinciding event survives.
    edge_capture_d = (edge_capture_q & ~clr) | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    case (pio_addr_e'(address))
      PIO_ADDR_DATA: readdata_d[WIDTH-1:0] = deb;
      PIO_ADDR_RAW:  readdata_d[WIDTH-1:0] = sync2_q;
      PIO_ADDR_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      PIO_ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_capture_q;
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      deb_d1_q       <= '0;
      edge_capture_q <= '0;
      irq_mask_q     <= '0;
      readdata_q     <= '0;
    end else begin
      sync1_q        <= in_port;
      sync2_q        <= sync1_q;
      deb_d1_q       <= deb;
      edge_capture_q <= edge_capture_d;
      irq_mask_q     <= irq_mask_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_pio_input_irq_debounced.sv
// Directed bench for the debounced input PIO (N=4, any-edge, W1C): reads push
// expected data/irq into a queue, a monitor pops and compares one clock later.
module tb_pio_input_irq_debounced;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [4:0]  in_port = 5'h00;
  logic [31:0] readdata;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  pio_input_irq_debounced #(
    .WIDTH(5), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .W1C_CAPTURE(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // readdata is registered, so a read sampled on one edge is valid after it.
  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_vld) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard: read result with no expected entry, readdata=%h", readdata);
      end else begin
        e = exp_q.pop_front();
        if (readdata !== e.data || irq !== e.irq) begin
          miscompares++;
          $display("FAIL %s: readdata=%h irq=%b, expected readdata=%h irq=%b",
                   e.name, readdata, irq, e.data, e.irq);
        end
      end
    end
  end

  // Tasks are entered at a negedge and return at the next one.
  task automatic rd(input logic [2:0] a, input logic [31:0] d, input logic i, input string n);
    exp_t e;
    e.name = n; e.data = d; e.irq = i;
    exp_q.push_back(e);
    address = a; chipselect = 1'b1; write_n = 1'b1; rd_req = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d vectors so far", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    // Inputs held high through reset
    in_port = 5'h1F;
    idle(3);
    reset = 1'b0;
    rd(3'd0, 32'h00, 1'b0, "rst_data");
    rd(3'd1, 32'h00, 1'b0, "rst_raw");
    rd(3'd2, 32'h00, 1'b0, "rst_mask");
    rd(3'd3, 32'h00, 1'b0, "rst_edge");
    rd(3'd1, 32'h1F, 1'b0, "raw_after_sync");
    rd(3'd0, 32'h00, 1'b0, "deb_not_yet_k6");
    rd(3'd3, 32'h00, 1'b0, "edge_not_yet_k7");
    rd(3'd0, 32'h1F, 1'b0, "deb_post_reset");
    rd(3'd3, 32'h1F, 1'b0, "edge_post_reset");
    in_port = 5'h00;
    idle(10);
    rd(3'd3, 32'h1F, 1'b0, "edge_fall_all");
    wr(3'd3, 32'h1F);
    rd(3'd3, 32'h00, 1'b0, "edge_cleared");

    // Three-cycle glitch on bit 0
    in_port = 5'h01;
    idle(3);
    in_port = 5'h00;
    idle(8);
    rd(3'd0, 32'h00, 1'b0, "glitch_data");
    rd(3'd3, 32'h00, 1'b0, "glitch_edge");

    // Debounced press with bit 0 unmasked
    wr(3'd2, 32'h01);
    in_port = 5'h01;
    rd(3'd1, 32'h00, 1'b0, "press_raw_k1");
    rd(3'd1, 32'h00, 1'b0, "press_raw_k2");
    rd(3'd1, 32'h01, 1'b0, "press_raw_k3");
    rd(3'd0, 32'h00, 1'b0, "press_data_k4");
    rd(3'd0, 32'h00, 1'b0, "press_data_k5");
    rd(3'd0, 32'h00, 1'b0, "press_data_k6");
    rd(3'd0, 32'h01, 1'b1, "press_data_irq_k7");
    rd(3'd3, 32'h01, 1'b1, "press_edge");
    wr(3'd5, 32'h1F);
    rd(3'd5, 32'h00, 1'b1, "unmapped_read");
    rd(3'd2, 32'h01, 1'b1, "mask_unchanged");

    // Write-1-to-clear of a single capture bit
    in_port = 5'h03;
    idle(8);
    rd(3'd3, 32'h03, 1'b1, "w1c_before");
    wr(3'd3, 32'h01);
    rd(3'd3, 32'h02, 1'b0, "w1c_after");
    wr(3'd2, 32'h03);
    rd(3'd2, 32'h03, 1'b1, "w1c_mask_bit1");
    wr(3'd2, 32'h01);
    wr(3'd3, 32'h1F);
    rd(3'd3, 32'h00, 1'b0, "w1c_clear_all");

    // Clear colliding with a new edge on bit 2
    in_port = 5'h07;
    idle(6);
    wr(3'd3, 32'h1F);
    rd(3'd3, 32'h04, 1'b0, "collision_set_wins");

    // Reset while a count is in progress and every capture bit is set
    in_port = 5'h18;
    idle(8);
    rd(3'd3, 32'h1F, 1'b1, "pre_reset_edge");
    in_port = 5'h19;
    idle(4);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    rd(3'd0, 32'h00, 1'b0, "midrst_data");
    rd(3'd1, 32'h00, 1'b0, "midrst_raw");
    rd(3'd2, 32'h00, 1'b0, "midrst_mask");
    rd(3'd3, 32'h00, 1'b0, "midrst_edge");
    rd(3'd1, 32'h19, 1'b0, "midrst_raw_sync");
    rd(3'd0, 32'h00, 1'b0, "midrst_full_hold");
    rd(3'd0, 32'h19, 1'b0, "midrst_deb");
    rd(3'd3, 32'h19, 1'b0, "midrst_edge_new");

    idle(2);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected reads never returned, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
